// File: rtl/mem_wb.sv
// ============================================================================
//  Module   : mem_wb
//  Purpose  : Memory stage with 4096x32 data memory, byte-lane stores,
//             sign/zero-extending loads and the MEM/WB pipeline register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_wb (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_pc,
    input  logic [31:0] E_instr,
    input  logic [31:0] E_data,
    input  logic [31:0] E_RD2,
    input  logic [3:0]  E_byteen,
    input  logic [4:0]  E_loadType,
    input  logic        E_about_DM,
    input  logic        E_RFWR,
    input  logic [4:0]  E_A3,
    input  logic [2:0]  E_tnew,
    output logic [31:0] M_pc,
    output logic [31:0] M_instr,
    output logic [31:0] M_data,
    output logic        M_RFWR,
    output logic [4:0]  M_A3,
    output logic [2:0]  M_tnew
);

    localparam int c_DM_WORDS = 4096;

    localparam int c_LT_LW  = 0;
    localparam int c_LT_LH  = 1;
    localparam int c_LT_LHU = 2;
    localparam int c_LT_LB  = 3;
    localparam int c_LT_LBU = 4;

    logic [31:0] mem_q [0:c_DM_WORDS-1];

    logic [11:0] w_word_idx;
    logic [31:0] w_rdata;
    logic [31:0] w_merged;
    logic        w_store;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_load;
    logic [31:0] M_data_d;
    logic [2:0]  M_tnew_d;

    // Upper address bits alias onto the same 16 KiB array.
    assign w_word_idx = E_data[13:2];
    assign w_rdata    = mem_q[w_word_idx];
    assign w_store    = E_about_DM && (E_byteen != 4'b0000);

    genvar g;
    generate
        for (g = 0; g < 4; g = g + 1) begin : g_lane
            assign w_merged[8*g +: 8] = E_byteen[g] ? E_RD2[8*g +: 8]
                                                    : w_rdata[8*g +: 8];
        end
    endgenerate

    always_comb begin
        w_half = E_data[1] ? w_rdata[31:16] : w_rdata[15:0];
        w_byte = 8'h00;
        case (E_data[1:0])
            2'd0:    w_byte = w_rdata[7:0];
            2'd1:    w_byte = w_rdata[15:8];
            2'd2:    w_byte = w_rdata[23:16];
            default: w_byte = w_rdata[31:24];
        endcase

        w_load = w_rdata;
        if (E_loadType[c_LT_LH]) begin
            w_load = {{16{w_half[15]}}, w_half};
        end else if (E_loadType[c_LT_LHU]) begin
            w_load = {16'h0000, w_half};
        end else if (E_loadType[c_LT_LB]) begin
            w_load = {{24{w_byte[7]}}, w_byte};
        end else if (E_loadType[c_LT_LBU]) begin
            w_load = {24'h000000, w_byte};
        end else if (E_loadType[c_LT_LW]) begin
            w_load = w_rdata;
        end

        M_data_d = (E_about_DM && (E_loadType != 5'b00000)) ? w_load : E_data;
        M_tnew_d = (E_tnew == 3'd0) ? 3'd0 : (E_tnew - 3'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_DM_WORDS; i++) begin
                mem_q[i] <= 32'h0;
            end
            M_pc    <= 32'h0;
            M_instr <= 32'h0;
            M_data  <= 32'h0;
            M_RFWR  <= 1'b0;
            M_A3    <= 5'd0;
            M_tnew  <= 3'd0;
        end else begin
            if (w_store) begin
                mem_q[w_word_idx] <= w_merged;
            end
            M_pc    <= E_pc;
            M_instr <= E_instr;
            M_data  <= M_data_d;
            M_RFWR  <= E_RFWR;
            M_A3    <= E_A3;
            M_tnew  <= M_tnew_d;
        end
    end

`ifndef SYNTHESIS
    // Store trace for simulation only; address is printed word-aligned.
    always @(posedge clk) begin
        if (!reset && w_store) begin
            $display("@%h: *%h <= %h", E_pc, {E_data[31:2], 2'b00}, w_merged);
        end
    end
`endif

    logic w_unused;
    assign w_unused = &{1'b0, E_data[31:14]};

endmodule

`default_nettype wire

// File: tb/tb_mem_wb.sv
// ============================================================================
//  Module   : tb_mem_wb
//  Purpose  : Self-checking bench for mem_wb against a byte-array memory model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_wb;

    logic        clk;
    logic        reset;
    logic [31:0] E_pc, E_instr, E_data, E_RD2;
    logic [3:0]  E_byteen;
    logic [4:0]  E_loadType;
    logic        E_about_DM, E_RFWR;
    logic [4:0]  E_A3;
    logic [2:0]  E_tnew;
    logic [31:0] M_pc, M_instr, M_data;
    logic        M_RFWR;
    logic [4:0]  M_A3;
    logic [2:0]  M_tnew;

    mem_wb dut (
        .clk        (clk),
        .reset      (reset),
        .E_pc       (E_pc),
        .E_instr    (E_instr),
        .E_data     (E_data),
        .E_RD2      (E_RD2),
        .E_byteen   (E_byteen),
        .E_loadType (E_loadType),
        .E_about_DM (E_about_DM),
        .E_RFWR     (E_RFWR),
        .E_A3       (E_A3),
        .E_tnew     (E_tnew),
        .M_pc       (M_pc),
        .M_instr    (M_instr),
        .M_data     (M_data),
        .M_RFWR     (M_RFWR),
        .M_A3       (M_A3),
        .M_tnew     (M_tnew)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: flat 16 KiB byte array, little-endian.
    logic [7:0]  mb [0:16383];
    logic [31:0] exp_pc, exp_instr, exp_data;
    logic        exp_rfwr;
    logic [4:0]  exp_a3;
    logic [2:0]  exp_tnew;
    int tests = 0;
    int fails = 0;

    localparam logic [4:0] LW = 5'b00001, LH = 5'b00010, LHU = 5'b00100,
                           LB = 5'b01000, LBU = 5'b10000;

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [4:0] lt);
        int unsigned a  = addr % 16384;
        int unsigned w  = a - (a % 4);
        int unsigned h  = w + (((a % 4) >= 2) ? 2 : 0);
        logic [15:0] hv = {mb[h+1], mb[h]};
        logic [7:0]  bv = mb[a];
        if (lt == LW)  return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
        if (lt == LH)  return {{16{hv[15]}}, hv};
        if (lt == LHU) return {16'h0, hv};
        if (lt == LB)  return {{24{bv[7]}}, bv};
        if (lt == LBU) return {24'h0, bv};
        return 32'h0;
    endfunction

    // Drives one instruction, updates the model, and returns #1 after the edge.
    task automatic step(input logic rst, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] data, input logic [31:0] rd2, input logic [3:0] be,
                        input logic [4:0] lt, input logic dm, input logic rfwr,
                        input logic [4:0] a3, input logic [2:0] tn);
        @(negedge clk);
        reset = rst; E_pc = pc; E_instr = instr; E_data = data; E_RD2 = rd2;
        E_byteen = be; E_loadType = lt; E_about_DM = dm; E_RFWR = rfwr;
        E_A3 = a3; E_tnew = tn;
        if (rst) begin
            for (int i = 0; i < 16384; i++) mb[i] = 8'h00;
            exp_pc = 0; exp_instr = 0; exp_data = 0; exp_rfwr = 0; exp_a3 = 0; exp_tnew = 0;
        end else begin
            exp_pc = pc; exp_instr = instr; exp_rfwr = rfwr; exp_a3 = a3;
            exp_tnew = (tn == 0) ? 3'd0 : 3'(tn - 1);
            exp_data = (dm && lt != 0) ? model_load(data, lt) : data;
            if (dm && be != 0)
                for (int i = 0; i < 4; i++)
                    if (be[i]) mb[(data % 16384) - (data % 4) + i] = rd2[8*i +: 8];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 32'h3000, 32'hAC000000, 32'h10, 32'hFFFFFFFF, 4'hF, 5'b0, 1, 1, 5'd9, 3'd4);
        tests++; if (M_pc !== 32'h0)    begin fails++; $display("FAIL reset_pc: got %h want 0", M_pc); end
        tests++; if (M_instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", M_instr); end
        tests++; if (M_data !== 32'h0)  begin fails++; $display("FAIL reset_data: got %h want 0", M_data); end
        tests++; if (M_RFWR !== 1'b0)   begin fails++; $display("FAIL reset_rfwr: got %b want 0", M_RFWR); end
        tests++; if (M_A3 !== 5'd0)     begin fails++; $display("FAIL reset_a3: got %h want 0", M_A3); end
        tests++; if (M_tnew !== 3'd0)   begin fails++; $display("FAIL reset_tnew: got %h want 0", M_tnew); end
    endtask

    task automatic test_word();
        step(0, 32'h3004, 32'hAC000001, 32'h10, 32'h12345678, 4'hF, 5'b0, 1, 0, 5'd0, 3'd0);
        tests++; if (M_data !== 32'h10) begin fails++; $display("FAIL sw_passthru: got %h want 00000010", M_data); end
        step(0, 32'h3008, 32'h8C000002, 32'h10, 32'h0, 4'h0, LW, 1, 1, 5'd8, 3'd2);
        tests++; if (M_data !== 32'h12345678) begin fails++; $display("FAIL lw_after_sw: got %h want 12345678", M_data); end
        tests++; if (M_tnew !== 3'd1) begin fails++; $display("FAIL lw_tnew: got %h want 1", M_tnew); end
    endtask

    task automatic test_byte();
        step(0, 32'h300C, 32'h80000003, 32'h13, 32'h0, 4'h0, LB, 1, 1, 5'd9, 3'd2);
        tests++; if (M_data !== 32'h00000012) begin fails++; $display("FAIL lb_pos: got %h want 00000012", M_data); end
        step(0, 32'h3010, 32'hA0000004, 32'h13, 32'h80000000, 4'b1000, 5'b0, 1, 0, 5'd0, 3'd0);
        step(0, 32'h3014, 32'h80000005, 32'h13, 32'h0, 4'h0, LB, 1, 1, 5'd9, 3'd2);
        tests++; if (M_data !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_neg: got %h want FFFFFF80", M_data); end
        step(0, 32'h3018, 32'h90000006, 32'h13, 32'h0, 4'h0, LBU, 1, 1, 5'd9, 3'd2);
        tests++; if (M_data !== 32'h00000080) begin fails++; $display("FAIL lbu: got %h want 00000080", M_data); end
        step(0, 32'h301C, 32'h8C000007, 32'h10, 32'h0, 4'h0, LW, 1, 1, 5'd9, 3'd2);
        tests++; if (M_data !== 32'h80345678) begin fails++; $display("FAIL sb_merge: got %h want 80345678", M_data); end
    endtask

    task automatic test_half();
        step(0, 32'h3020, 32'hAC000008, 32'h20, 32'h80017FFF, 4'hF, 5'b0, 1, 0, 5'd0, 3'd0);
        step(0, 32'h3024, 32'h84000009, 32'h22, 32'h0, 4'h0, LH, 1, 1, 5'd10, 3'd2);
        tests++; if (M_data !== 32'hFFFF8001) begin fails++; $display("FAIL lh_hi: got %h want FFFF8001", M_data); end
        step(0, 32'h3028, 32'h9400000A, 32'h22, 32'h0, 4'h0, LHU, 1, 1, 5'd10, 3'd2);
        tests++; if (M_data !== 32'h00008001) begin fails++; $display("FAIL lhu_hi: got %h want 00008001", M_data); end
        step(0, 32'h302C, 32'h8400000B, 32'h20, 32'h0, 4'h0, LH, 1, 1, 5'd10, 3'd2);
        tests++; if (M_data !== 32'h00007FFF) begin fails++; $display("FAIL lh_lo: got %h want 00007FFF", M_data); end
        step(0, 32'h3030, 32'h8400000C, 32'h23, 32'h0, 4'h0, LH, 1, 1, 5'd10, 3'd2);
        tests++; if (M_data !== 32'hFFFF8001) begin fails++; $display("FAIL lh_off0_ignored: got %h want FFFF8001", M_data); end
    endtask

    task automatic test_passthru();
        step(0, 32'h3034, 32'h0000000D, 32'hDEADBEEF, 32'h0, 4'h0, 5'b0, 0, 1, 5'd5, 3'd1);
        tests++; if (M_data !== 32'hDEADBEEF) begin fails++; $display("FAIL pt_data: got %h want DEADBEEF", M_data); end
        tests++; if (M_RFWR !== 1'b1) begin fails++; $display("FAIL pt_rfwr: got %b want 1", M_RFWR); end
        tests++; if (M_A3 !== 5'd5)   begin fails++; $display("FAIL pt_a3: got %h want 5", M_A3); end
        tests++; if (M_tnew !== 3'd0) begin fails++; $display("FAIL pt_tnew1: got %h want 0", M_tnew); end
        tests++; if (M_pc !== 32'h3034) begin fails++; $display("FAIL pt_pc: got %h want 00003034", M_pc); end
        step(0, 32'h3038, 32'h0000000E, 32'h1, 32'h0, 4'h0, 5'b0, 0, 1, 5'd6, 3'd0);
        tests++; if (M_tnew !== 3'd0) begin fails++; $display("FAIL pt_tnew0_sat: got %h want 0", M_tnew); end
        step(0, 32'h303C, 32'h0000000F, 32'h2, 32'h0, 4'h0, 5'b0, 0, 1, 5'd7, 3'd7);
        tests++; if (M_tnew !== 3'd6) begin fails++; $display("FAIL pt_tnew7: got %h want 6", M_tnew); end
        // Load kind with E_about_DM low must still pass E_data through.
        step(0, 32'h3040, 32'h00000010, 32'h10, 32'h0, 4'h0, LW, 0, 1, 5'd7, 3'd1);
        tests++; if (M_data !== 32'h10) begin fails++; $display("FAIL pt_lt_no_dm: got %h want 00000010", M_data); end
    endtask

    task automatic test_bubble_and_nodm();
        step(0, 32'h3044, 32'h0, 32'h0, 32'h0, 4'h0, 5'b0, 0, 0, 5'd0, 3'd0);
        tests++; if (M_RFWR !== 1'b0 || M_instr !== 32'h0) begin
            fails++; $display("FAIL bubble: got rfwr=%b instr=%h want 0/0", M_RFWR, M_instr); end
        step(0, 32'h3048, 32'hAC000011, 32'h30, 32'h55555555, 4'hF, 5'b0, 0, 0, 5'd0, 3'd0);
        step(0, 32'h304C, 32'h8C000012, 32'h30, 32'h0, 4'h0, LW, 1, 1, 5'd3, 3'd2);
        tests++; if (M_data !== 32'h0) begin fails++; $display("FAIL store_no_dm: got %h want 00000000", M_data); end
    endtask

    task automatic test_reset_store();
        step(1, 32'h3050, 32'hAC000013, 32'h40, 32'hAAAAAAAA, 4'hF, 5'b0, 1, 1, 5'd4, 3'd3);
        tests++; if ({M_pc, M_instr, M_data, M_RFWR, M_A3, M_tnew} !== 106'h0) begin
            fails++; $display("FAIL rst_store_outs: got pc=%h instr=%h data=%h want all 0", M_pc, M_instr, M_data); end
        step(0, 32'h3054, 32'h8C000014, 32'h40, 32'h0, 4'h0, LW, 1, 1, 5'd4, 3'd2);
        tests++; if (M_data !== 32'h0) begin fails++; $display("FAIL rst_store_suppressed: got %h want 00000000", M_data); end
        step(0, 32'h3058, 32'h8C000015, 32'h10, 32'h0, 4'h0, LW, 1, 1, 5'd4, 3'd2);
        tests++; if (M_data !== 32'h0) begin fails++; $display("FAIL rst_mem_cleared: got %h want 00000000", M_data); end
    endtask

    task automatic test_alias();
        step(0, 32'h305C, 32'hAC000016, 32'h00004004, 32'hCAFEF00D, 4'hF, 5'b0, 1, 0, 5'd0, 3'd0);
        step(0, 32'h3060, 32'h8C000017, 32'h4, 32'h0, 4'h0, LW, 1, 1, 5'd2, 3'd2);
        tests++; if (M_data !== 32'hCAFEF00D) begin fails++; $display("FAIL alias: got %h want CAFEF00D", M_data); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] addr;
            int op;
            logic rst;
            addr = ($urandom & 32'hFFFFC000) | 32'($urandom_range(0, 63));
            op   = $urandom_range(0, 2);
            rst  = ($urandom_range(0, 79) == 0);
            case (op)
                0: step(rst, $urandom, $urandom, addr, $urandom, 4'($urandom_range(1, 15)), 5'b0,
                        ($urandom_range(0, 3) != 0), $urandom_range(0, 1), 5'($urandom), 3'($urandom));
                1: step(rst, $urandom, $urandom, addr, $urandom, 4'h0, 5'(1 << $urandom_range(0, 4)),
                        ($urandom_range(0, 5) != 0), 1, 5'($urandom), 3'($urandom));
                default: step(rst, $urandom, $urandom, $urandom, $urandom, 4'h0, 5'b0, 0,
                        $urandom_range(0, 1), 5'($urandom), 3'($urandom));
            endcase
            tests++;
            if (M_pc !== exp_pc || M_instr !== exp_instr || M_data !== exp_data ||
                M_RFWR !== exp_rfwr || M_A3 !== exp_a3 || M_tnew !== exp_tnew) begin
                fails++;
                $display("FAIL random[%0d]: got pc=%h ins=%h d=%h wr=%b a3=%h tn=%h want pc=%h ins=%h d=%h wr=%b a3=%h tn=%h",
                         n, M_pc, M_instr, M_data, M_RFWR, M_A3, M_tnew,
                         exp_pc, exp_instr, exp_data, exp_rfwr, exp_a3, exp_tnew);
            end
        end
    endtask

    initial begin
        reset = 1'b1; E_pc = 0; E_instr = 0; E_data = 0; E_RD2 = 0; E_byteen = 0;
        E_loadType = 0; E_about_DM = 0; E_RFWR = 0; E_A3 = 0; E_tnew = 0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_passthru();
        test_bubble_and_nodm();
        test_reset_store();
        test_alias();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
